// File: rtl/pe_tile_param.sv
// Parametrised CGRA PE tile: config register file with read-back, two connect boxes,
// a registered PE (including accumulate), and a switch box with per-track optional pipelining.
module pe_tile_param #(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned TRACKS        = 4,
  parameter int unsigned TILE_ID_CHECK = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              config_addr,
  input  logic [31:0]              config_data,
  input  logic                     config_we,
  input  logic [15:0]              tile_id,
  input  logic [TRACKS*WIDTH-1:0]  in_side0,
  input  logic [TRACKS*WIDTH-1:0]  in_side1,
  input  logic [TRACKS*WIDTH-1:0]  in_side2,
  input  logic [TRACKS*WIDTH-1:0]  in_side3,
  output logic [TRACKS*WIDTH-1:0]  out_side0,
  output logic [TRACKS*WIDTH-1:0]  out_side1,
  output logic [TRACKS*WIDTH-1:0]  out_side2,
  output logic [TRACKS*WIDTH-1:0]  out_side3,
  output logic [31:0]              read_data,
  output logic [WIDTH-1:0]         pe_out
);

  localparam int unsigned BUS = TRACKS * WIDTH;
  localparam int unsigned S   = $clog2(2 * TRACKS);
  localparam int unsigned SBW = 3 * TRACKS;

  logic [7:0]       w_id;
  logic             w_match;
  logic             w_hit;
  logic [2:0]       r_op;
  logic [S-1:0]     r_cb0;
  logic [S-1:0]     r_cb1;
  logic [SBW-1:0]   r_sb_cfg [4];
  logic [31:0]      w_rd;
  logic [31:0]      r_read_data;
  logic [WIDTH-1:0] r_pe;
  logic [WIDTH-1:0] w_pe_next;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [BUS-1:0]   w_in [4];
  logic [BUS-1:0]   w_sb_mux [4];
  logic [BUS-1:0]   w_out [4];
  logic [BUS-1:0]   r_sb [4];
  logic [1:0]       w_sel;
  logic [1:0]       w_src;
  logic             w_unused;

  assign w_unused = &{1'b0, config_addr[31:24], config_data};

  assign w_id    = config_addr[23:16];
  assign w_match = (TILE_ID_CHECK != 0) ? (config_addr[15:0] == tile_id) : 1'b1;
  assign w_hit   = config_we & w_match & (w_id <= 8'd6);

  // Config register file; unused bits are simply not stored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op  <= '0;
      r_cb0 <= '0;
      r_cb1 <= '0;
      for (int s = 0; s < 4; s++) r_sb_cfg[s] <= '0;
    end else if (w_hit) begin
      case (w_id)
        8'd0: r_op        <= config_data[2:0];
        8'd1: r_cb0       <= config_data[S-1:0];
        8'd2: r_cb1       <= config_data[S-1:0];
        8'd3: r_sb_cfg[0] <= config_data[SBW-1:0];
        8'd4: r_sb_cfg[1] <= config_data[SBW-1:0];
        8'd5: r_sb_cfg[2] <= config_data[SBW-1:0];
        8'd6: r_sb_cfg[3] <= config_data[SBW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_match) begin
      case (w_id)
        8'd0: w_rd = 32'(r_op);
        8'd1: w_rd = 32'(r_cb0);
        8'd2: w_rd = 32'(r_cb1);
        8'd3: w_rd = 32'(r_sb_cfg[0]);
        8'd4: w_rd = 32'(r_sb_cfg[1]);
        8'd5: w_rd = 32'(r_sb_cfg[2]);
        8'd6: w_rd = 32'(r_sb_cfg[3]);
        default: w_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_read_data <= '0;
    else        r_read_data <= w_rd;
  end

  assign read_data = r_read_data;

  assign w_in[0] = in_side0;
  assign w_in[1] = in_side1;
  assign w_in[2] = in_side2;
  assign w_in[3] = in_side3;

  // Switch box: selects 0..2 walk the other three sides in ascending order, 3 is the PE
  always_comb begin
    w_sel = '0;
    w_src = '0;
    for (int s = 0; s < 4; s++) begin
      w_sb_mux[s] = '0;
      w_out[s]    = '0;
    end
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < TRACKS; t++) begin
        w_sel = r_sb_cfg[s][2*t +: 2];
        w_src = (w_sel >= 2'(s)) ? w_sel + 2'd1 : w_sel;
        if (w_sel == 2'd3) w_sb_mux[s][t*WIDTH +: WIDTH] = r_pe;
        else               w_sb_mux[s][t*WIDTH +: WIDTH] = w_in[w_src][t*WIDTH +: WIDTH];
        w_out[s][t*WIDTH +: WIDTH] = r_sb_cfg[s][2*TRACKS + t] ? r_sb[s][t*WIDTH +: WIDTH]
                                                                : w_sb_mux[s][t*WIDTH +: WIDTH];
      end
    end
  end

  // Pipeline registers capture every cycle so toggling reg-enable never exposes stale data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 4; s++) r_sb[s] <= '0;
    end else begin
      for (int s = 0; s < 4; s++) r_sb[s] <= w_sb_mux[s];
    end
  end

  assign out_side0 = w_out[0];
  assign out_side1 = w_out[1];
  assign out_side2 = w_out[2];
  assign out_side3 = w_out[3];

  // Connect boxes on side 0; upper half of the index space feeds back from out_side0
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < TRACKS; k++) begin
      if (r_cb0 == S'(k))          w_a = in_side0[k*WIDTH +: WIDTH];
      if (r_cb0 == S'(k + TRACKS)) w_a = w_out[0][k*WIDTH +: WIDTH];
      if (r_cb1 == S'(k))          w_b = in_side0[k*WIDTH +: WIDTH];
      if (r_cb1 == S'(k + TRACKS)) w_b = w_out[0][k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_pe_next = '0;
    case (r_op)
      3'd0: w_pe_next = w_a + w_b;
      3'd1: w_pe_next = w_a - w_b;
      3'd2: w_pe_next = w_a & w_b;
      3'd3: w_pe_next = w_a | w_b;
      3'd4: w_pe_next = w_a ^ w_b;
      3'd5: w_pe_next = w_a;
      3'd6: w_pe_next = WIDTH'(w_a < w_b);
      3'd7: w_pe_next = r_pe + w_a;
      default: w_pe_next = '0;
    endcase
  end

  // Writing the PE register restarts accumulation from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         r_pe <= '0;
    else if (w_hit && (w_id == 8'd0))   r_pe <= '0;
    else                                r_pe <= w_pe_next;
  end

  assign pe_out = r_pe;

endmodule

// File: tb/tb_pe_tile_param.sv
// Bench for pe_tile_param (WIDTH=8, TRACKS=4): directed scenarios plus random traffic
// checked every cycle against an arithmetic reference model.
module tb_pe_tile_param;

  logic        clk;
  logic        reset;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_we;
  logic [15:0] tile_id;
  logic [31:0] in_s [4];
  logic [31:0] out_s0, out_s1, out_s2, out_s3;
  logic [31:0] read_data;
  logic [7:0]  pe_out;

  int checks = 0;
  int errors = 0;

  pe_tile_param #(.WIDTH(8), .TRACKS(4), .TILE_ID_CHECK(1)) dut (
    .clk(clk), .reset(reset),
    .config_addr(config_addr), .config_data(config_data), .config_we(config_we),
    .tile_id(tile_id),
    .in_side0(in_s[0]), .in_side1(in_s[1]), .in_side2(in_s[2]), .in_side3(in_s[3]),
    .out_side0(out_s0), .out_side1(out_s1), .out_side2(out_s2), .out_side3(out_s3),
    .read_data(read_data), .pe_out(pe_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_reg [7];
  logic [7:0]  m_pe;
  logic [7:0]  m_sbreg [4][4];
  logic [31:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_reg[i] = '0;
    for (int s = 0; s < 4; s++) for (int t = 0; t < 4; t++) m_sbreg[s][t] = '0;
    m_pe = '0;
    m_rd = '0;
  endtask

  function automatic logic [7:0] exp_mux(int s, int t);
    int sel;
    int k;
    sel = int'((m_reg[3+s] >> (2*t)) & 32'd3);
    if (sel == 3) return m_pe;
    k = 0;
    for (int side = 0; side < 4; side++) begin
      if (side != s) begin
        if (k == sel) return in_s[side][8*t +: 8];
        k++;
      end
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_track(int s, int t);
    if (m_reg[3+s][8+t]) return m_sbreg[s][t];
    return exp_mux(s, t);
  endfunction

  function automatic logic [31:0] exp_side(int s);
    logic [31:0] r;
    for (int t = 0; t < 4; t++) r[8*t +: 8] = exp_track(s, t);
    return r;
  endfunction

  function automatic logic [7:0] exp_opnd(logic [31:0] idx);
    if (idx < 4) return in_s[0][8*idx +: 8];
    if (idx < 8) return exp_track(0, int'(idx) - 4);
    return 8'h00;
  endfunction

  task automatic model_update();
    logic [7:0]  nsb [4][4];
    logic [7:0]  a, b, npe;
    logic [7:0]  id;
    logic        match, hit;
    logic [31:0] mask;
    for (int s = 0; s < 4; s++) for (int t = 0; t < 4; t++) nsb[s][t] = exp_mux(s, t);
    a = exp_opnd(m_reg[1]);
    b = exp_opnd(m_reg[2]);
    case (m_reg[0][2:0])
      3'd0: npe = 8'(a + b);
      3'd1: npe = 8'(a - b);
      3'd2: npe = a & b;
      3'd3: npe = a | b;
      3'd4: npe = a ^ b;
      3'd5: npe = a;
      3'd6: npe = (a < b) ? 8'd1 : 8'd0;
      default: npe = 8'(m_pe + a);
    endcase
    id    = config_addr[23:16];
    match = (config_addr[15:0] == tile_id);
    hit   = config_we && match && (id <= 8'd6);
    m_rd  = (match && id <= 8'd6) ? m_reg[id] : 32'h0;
    if (hit) begin
      mask = (id == 8'd0) ? 32'h7 : (id <= 8'd2) ? 32'h7 : 32'hFFF;
      m_reg[id] = config_data & mask;
      if (id == 8'd0) npe = 8'h00;
    end
    m_pe = npe;
    for (int s = 0; s < 4; s++) for (int t = 0; t < 4; t++) m_sbreg[s][t] = nsb[s][t];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("pe_out", 32'(pe_out), 32'(m_pe));
    chk("read_data", read_data, m_rd);
    chk("out_side0", out_s0, exp_side(0));
    chk("out_side1", out_s1, exp_side(1));
    chk("out_side2", out_s2, exp_side(2));
    chk("out_side3", out_s3, exp_side(3));
  endtask

  task automatic cycle();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [15:0] tile, input logic [7:0] id, input logic [31:0] data);
    config_addr = {8'h00, id, tile};
    config_data = data;
    config_we   = 1'b1;
    cycle();
    config_we   = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int s = 0; s < 4; s++) in_s[s] = $urandom;
  endtask

  initial begin
    logic [7:0] prev;
    tile_id     = 16'd5;
    reset       = 1'b0;
    config_we   = 1'b0;
    config_addr = '0;
    config_data = '0;
    rand_inputs();
    model_reset();

    // Reset held: random inputs including write strobes must not disturb anything
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      config_addr = $urandom;
      config_data = $urandom;
      config_we   = 1'($urandom);
      #1;
      compare_all();
      chk("rst_side1", out_s1, in_s[0]);
      @(negedge clk);
    end
    config_we   = 1'b0;
    config_addr = '0;
    reset       = 1'b1;
    rand_inputs();

    // Config write and read-back
    cfg_wr(16'd5, 8'd3, 32'hFFFF_FFFF);
    cycle();
    chk("rd_sb0", read_data, 32'h0000_0FFF);
    cfg_wr(16'd6, 8'd3, 32'h0);
    config_addr = {8'h00, 8'd3, 16'd5};
    cycle();
    chk("rd_nochg", read_data, 32'h0000_0FFF);
    config_addr = {8'h00, 8'd9, 16'd5};
    cycle();
    chk("rd_id9", read_data, 32'h0);
    cfg_wr(16'd5, 8'd3, 32'h0);

    // PE add with wrap
    cfg_wr(16'd5, 8'd1, 32'd0);
    cfg_wr(16'd5, 8'd2, 32'd1);
    in_s[0] = {16'($urandom), 8'h20, 8'hF0};
    cfg_wr(16'd5, 8'd0, 32'd0);
    cycle();
    chk("pe_add_wrap", 32'(pe_out), 32'h10);

    // Accumulate, async reset mid-run, restart
    in_s[0][7:0] = 8'd3;
    cfg_wr(16'd5, 8'd0, 32'd7);
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("acc", 32'(pe_out), 32'(3 * i));
    end
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("acc_rst", 32'(pe_out), 32'h0);
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    cycle();
    cycle();
    cfg_wr(16'd5, 8'd0, 32'd7);
    cycle();
    chk("acc_restart", 32'(pe_out), 32'd3);

    // Side 2 track 1 from the PE, registered then combinational
    cfg_wr(16'd5, 8'd5, 32'h20C);
    for (int i = 0; i < 3; i++) begin
      prev = m_pe;
      cycle();
      chk("sb_reg", 32'(out_s2[15:8]), 32'(prev));
    end
    cfg_wr(16'd5, 8'd5, 32'h00C);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("sb_comb", 32'(out_s2[15:8]), 32'(m_pe));
    end

    // Feedback through out_side0 holds the PE value under pass
    cfg_wr(16'd5, 8'd3, 32'h3);
    cfg_wr(16'd5, 8'd1, 32'd0);
    in_s[0][7:0] = 8'h5A;
    cfg_wr(16'd5, 8'd0, 32'd5);
    cycle();
    chk("cb_fb_load", 32'(pe_out), 32'h5A);
    cfg_wr(16'd5, 8'd1, 32'd4);
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      cycle();
      chk("cb_fb_hold", 32'(pe_out), 32'h5A);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      config_addr = {8'($urandom), 8'($urandom_range(0, 9)),
                     (($urandom % 4) == 0) ? 16'd6 : 16'd5};
      config_data = $urandom;
      config_we   = (($urandom % 3) == 0);
      cycle();
    end
    config_we = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
